// File: rtl/i2c_master.sv
// I2C master for single-byte register writes and reads.
// SCL is generated from a quarter-period divider; SDA is driven open-drain style
// (oSDA=1 releases the line, oSDA=0 pulls it low). All line levels are registered.
module i2c_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] dev_addr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    input  logic       iSDA,
    output logic       SCL,
    output logic       oSDA,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    localparam logic [9:0] DIV_MAX = 10'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_START   = 4'd1,
        S_TX_BIT  = 4'd2,
        S_TX_ACK  = 4'd3,
        S_RESTART = 4'd4,
        S_RX_BIT  = 4'd5,
        S_RX_NACK = 4'd6,
        S_STOP    = 4'd7,
        S_FIN     = 4'd8
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] qtr_q, qtr_d;       // quarter within the current 4-quarter phase
    logic [2:0] bit_q, bit_d;       // bit index, counts 7 down to 0
    logic [1:0] byte_q, byte_d;     // 0: addr+W, 1: register, 2: data or addr+R
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       nack_q, nack_d;     // SDA level sampled in the ACK slot
    logic       rw_q, rw_d;
    logic [6:0] dev_q, dev_d;
    logic [7:0] reg_q, reg_d;
    logic [7:0] wdata_q, wdata_d;
    logic [9:0] div_q, div_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ack_err_q, ack_err_d;
    logic [7:0] rdata_q, rdata_d;

    logic       qtick_s;
    logic       accept_s;

    // Line levels {SCL, SDA} for a given phase and quarter.
    function automatic logic [1:0] line_levels(input state_e st, input logic [1:0] qtr,
                                               input logic tx_bit);
        logic [1:0] lv;
        lv = 2'b11;
        case (st)
            S_START:   lv = (qtr < 2'd2) ? 2'b11 : 2'b10;
            S_TX_BIT:  lv = {qtr[1], tx_bit};
            S_TX_ACK,
            S_RX_BIT,
            S_RX_NACK: lv = {qtr[1], 1'b1};
            S_RESTART: begin
                case (qtr)
                    2'd0:    lv = 2'b01;
                    2'd1:    lv = 2'b11;
                    default: lv = 2'b10;
                endcase
            end
            S_STOP: begin
                case (qtr)
                    2'd0:    lv = 2'b00;
                    2'd1:    lv = 2'b10;
                    default: lv = 2'b11;
                endcase
            end
            default:   lv = 2'b11;
        endcase
        return lv;
    endfunction

    assign qtick_s  = busy_q && (div_q == DIV_MAX);
    assign accept_s = start && !busy_q;

    // Next-state logic: command accept, quarter sequencing and byte scheduling.
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        nack_d    = nack_q;
        rw_d      = rw_q;
        dev_d     = dev_q;
        reg_d     = reg_q;
        wdata_d   = wdata_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        rdata_d   = rdata_q;

        if (busy_q) begin
            div_d = qtick_s ? 10'd0 : div_q + 10'd1;
        end else begin
            div_d = 10'd0;
        end

        if (state_q == S_FIN) begin
            // Single-cycle wrap-up after STOP; read data only commits if every ACK was good.
            state_d = S_IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            if (rw_q && !ack_err_q) begin
                rdata_d = rx_q;
            end else begin
                rdata_d = rdata_q;
            end
        end else if (accept_s) begin
            rw_d      = rw;
            dev_d     = dev_addr;
            reg_d     = reg_addr;
            wdata_d   = wdata;
            busy_d    = 1'b1;
            ack_err_d = 1'b0;
            div_d     = 10'd0;
            state_d   = S_START;
            qtr_d     = 2'd0;
            bit_d     = 3'd7;
            byte_d    = 2'd0;
            tx_d      = {dev_addr, 1'b0};
        end else if (qtick_s) begin
            qtr_d = qtr_q + 2'd1;
            // End of Q2 is the SCL-high sampling point.
            if (qtr_q == 2'd2) begin
                case (state_q)
                    S_TX_ACK: nack_d = iSDA;
                    S_RX_BIT: rx_d   = {rx_q[6:0], iSDA};
                    default:  nack_d = nack_q;
                endcase
            end else if (qtr_q == 2'd3) begin
                case (state_q)
                    S_START: begin
                        state_d = S_TX_BIT;
                        bit_d   = 3'd7;
                    end
                    S_TX_BIT: begin
                        if (bit_q == 3'd0) begin
                            state_d = S_TX_ACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                    S_TX_ACK: begin
                        bit_d = 3'd7;
                        if (nack_q) begin
                            ack_err_d = 1'b1;
                            state_d   = S_STOP;
                        end else begin
                            case (byte_q)
                                2'd0: begin
                                    tx_d    = reg_q;
                                    byte_d  = 2'd1;
                                    state_d = S_TX_BIT;
                                end
                                2'd1: begin
                                    if (rw_q) begin
                                        state_d = S_RESTART;
                                    end else begin
                                        tx_d    = wdata_q;
                                        byte_d  = 2'd2;
                                        state_d = S_TX_BIT;
                                    end
                                end
                                default: begin
                                    state_d = rw_q ? S_RX_BIT : S_STOP;
                                end
                            endcase
                        end
                    end
                    S_RESTART: begin
                        tx_d    = {dev_q, 1'b1};
                        byte_d  = 2'd2;
                        bit_d   = 3'd7;
                        state_d = S_TX_BIT;
                    end
                    S_RX_BIT: begin
                        if (bit_q == 3'd0) begin
                            state_d = S_RX_NACK;
                        end else begin
                            bit_d = bit_q - 3'd1;
                        end
                    end
                    S_RX_NACK: state_d = S_STOP;
                    S_STOP:    state_d = S_FIN;
                    default:   state_d = S_IDLE;
                endcase
            end else begin
                nack_d = nack_q;
            end
        end else begin
            state_d = state_q;
        end

        {scl_d, sda_d} = line_levels(state_d, qtr_d, tx_d[bit_d]);
    end

    // State and output registers; reset releases both lines immediately.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            byte_q    <= 2'd0;
            tx_q      <= 8'h00;
            rx_q      <= 8'h00;
            nack_q    <= 1'b0;
            rw_q      <= 1'b0;
            dev_q     <= 7'h00;
            reg_q     <= 8'h00;
            wdata_q   <= 8'h00;
            div_q     <= 10'd0;
            scl_q     <= 1'b1;
            sda_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            rdata_q   <= 8'h00;
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            nack_q    <= nack_d;
            rw_q      <= rw_d;
            dev_q     <= dev_d;
            reg_q     <= reg_d;
            wdata_q   <= wdata_d;
            div_q     <= div_d;
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            rdata_q   <= rdata_d;
        end
    end

    assign SCL     = scl_q;
    assign oSDA    = sda_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule
